// File: rtl/riscv_dmem_tcm.sv
// Tightly-coupled data memory for the EX-stage dmem_* request port: one access at a
// time, size/alignment and range checks, byte-lane writes, programmable latency.
package riscv_dmem_tcm_pkg;
  typedef enum logic [1:0] {
    BYTE  = 2'b00,
    HWORD = 2'b01,
    WORD  = 2'b10,
    DWORD = 2'b11
  } biu_size_t;
endpackage

module riscv_dmem_tcm
  import riscv_dmem_tcm_pkg::*;
#(
  parameter int unsigned     XLEN    = 32,
  parameter logic [XLEN-1:0] BASE    = '0,
  parameter int unsigned     DEPTH   = 1024,
  parameter int unsigned     LATENCY = 1
) (
  input  logic            rstn,
  input  logic            clk,
  input  logic            dmem_req,
  input  logic            dmem_we,
  input  logic [XLEN-1:0] dmem_adr,
  input  logic [XLEN-1:0] dmem_d,
  input  biu_size_t       dmem_size,
  output logic            dmem_ack,
  output logic [XLEN-1:0] dmem_q,
  output logic            dmem_misaligned,
  output logic            dmem_page_fault
);

  localparam int unsigned     AW       = $clog2(DEPTH);
  localparam logic [XLEN-1:0] SPAN     = XLEN'(4 * DEPTH);
  localparam logic [3:0]      CNT_LOAD = 4'(LATENCY - 1);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("riscv_dmem_tcm: LATENCY must be in 1..15");
  end
  if (XLEN != 32) begin : g_bad_xlen
    $error("riscv_dmem_tcm: only XLEN=32 is supported");
  end
  if ((DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("riscv_dmem_tcm: DEPTH must be a power of two");
  end

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [3:0]      r_cnt;
  logic            r_we;
  logic [XLEN-1:0] r_adr;
  logic [XLEN-1:0] r_d;
  biu_size_t       r_size;
  logic            r_ack;
  logic [XLEN-1:0] r_q;
  logic            r_mis;
  logic            r_pf;
  logic [XLEN-1:0] r_mem [DEPTH];

  logic            w_capture;
  logic            w_access;
  logic            w_cur_we;
  logic [XLEN-1:0] w_cur_adr;
  logic [XLEN-1:0] w_cur_d;
  biu_size_t       w_cur_size;
  logic [XLEN-1:0] w_off;
  logic            w_mis;
  logic            w_pf;
  logic [AW-1:0]   w_idx;
  logic [3:0]      w_be;
  logic [XLEN-1:0] w_wdata;
  logic            w_mem_we;

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE, S_RESP: begin
        if (dmem_req) begin
          w_capture   = 1'b1;
          w_state_nxt = (LATENCY == 1) ? S_RESP : S_BUSY;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_BUSY: begin
        if (r_cnt == 4'd1) begin
          w_state_nxt = S_RESP;
        end else begin
          w_state_nxt = S_BUSY;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_access = rstn && (w_state_nxt == S_RESP);
  end

  // With LATENCY=1 the access shares the capture edge, so decode from the live inputs.
  always_comb begin
    if (r_state == S_BUSY) begin
      w_cur_we   = r_we;
      w_cur_adr  = r_adr;
      w_cur_d    = r_d;
      w_cur_size = r_size;
    end else begin
      w_cur_we   = dmem_we;
      w_cur_adr  = dmem_adr;
      w_cur_d    = dmem_d;
      w_cur_size = dmem_size;
    end
    w_off = w_cur_adr - BASE;
    w_idx = w_off[AW+1:2];
    case (w_cur_size)
      BYTE: begin
        w_mis   = 1'b0;
        w_be    = 4'b0001 << w_cur_adr[1:0];
        w_wdata = {4{w_cur_d[7:0]}};
      end
      HWORD: begin
        w_mis   = w_cur_adr[0];
        w_be    = 4'b0011 << w_cur_adr[1:0];
        w_wdata = {2{w_cur_d[15:0]}};
      end
      WORD: begin
        w_mis   = |w_cur_adr[1:0];
        w_be    = 4'b1111;
        w_wdata = w_cur_d;
      end
      default: begin
        w_mis   = 1'b1;
        w_be    = 4'b0000;
        w_wdata = w_cur_d;
      end
    endcase
    w_pf     = !w_mis && (w_off >= SPAN);
    w_mem_we = w_access && w_cur_we && !w_mis && !w_pf;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_adr   <= '0;
      r_d     <= '0;
      r_size  <= BYTE;
    end else begin
      r_state <= w_state_nxt;
      if (w_capture) begin
        r_cnt  <= CNT_LOAD;
        r_we   <= dmem_we;
        r_adr  <= dmem_adr;
        r_d    <= dmem_d;
        r_size <= dmem_size;
      end else if (r_state == S_BUSY && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ack <= 1'b0;
      r_q   <= '0;
      r_mis <= 1'b0;
      r_pf  <= 1'b0;
    end else begin
      r_ack <= w_access;
      r_mis <= w_access && w_mis;
      r_pf  <= w_access && w_pf;
      if (w_access && !w_cur_we && !w_mis && !w_pf) begin
        r_q <= r_mem[w_idx];
      end else begin
        r_q <= '0;
      end
    end
  end

  // SRAM array: no reset, lane-masked write.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
        end
      end
    end
  end

  assign dmem_ack        = r_ack;
  assign dmem_q          = r_q;
  assign dmem_misaligned = r_mis;
  assign dmem_page_fault = r_pf;

endmodule

// File: tb/tb_riscv_dmem_tcm.sv
// Scoreboard bench for riscv_dmem_tcm: three instances cover LATENCY=1/BASE=0,
// LATENCY=1/BASE=0x1000 (range checks) and LATENCY=4/BASE=0 (timing, reset abort).
module tb_riscv_dmem_tcm;
  import riscv_dmem_tcm_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req, we;
  logic [31:0] adr, d;
  biu_size_t   size;
  int          sel;

  logic        ack_a, ack_b, ack_c;
  logic [31:0] q_a, q_b, q_c;
  logic        mis_a, mis_b, mis_c, pf_a, pf_b, pf_c;

  typedef struct {
    logic [31:0] q;
    logic        chk_q;
    logic        mis;
    logic        pf;
  } want_t;

  want_t       qa[$], qb[$], qc[$];
  logic [31:0] mdl[int];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  riscv_dmem_tcm #(.BASE(32'h0000_0000), .DEPTH(1024), .LATENCY(1)) u_a (
    .rstn(rstn), .clk(clk), .dmem_req(req && sel == 0), .dmem_we(we), .dmem_adr(adr),
    .dmem_d(d), .dmem_size(size), .dmem_ack(ack_a), .dmem_q(q_a),
    .dmem_misaligned(mis_a), .dmem_page_fault(pf_a));

  riscv_dmem_tcm #(.BASE(32'h0000_1000), .DEPTH(1024), .LATENCY(1)) u_b (
    .rstn(rstn), .clk(clk), .dmem_req(req && sel == 1), .dmem_we(we), .dmem_adr(adr),
    .dmem_d(d), .dmem_size(size), .dmem_ack(ack_b), .dmem_q(q_b),
    .dmem_misaligned(mis_b), .dmem_page_fault(pf_b));

  riscv_dmem_tcm #(.BASE(32'h0000_0000), .DEPTH(1024), .LATENCY(4)) u_c (
    .rstn(rstn), .clk(clk), .dmem_req(req && sel == 2), .dmem_we(we), .dmem_adr(adr),
    .dmem_d(d), .dmem_size(size), .dmem_ack(ack_c), .dmem_q(q_c),
    .dmem_misaligned(mis_c), .dmem_page_fault(pf_c));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, wanted %h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic ack_of(input int s);
    case (s)
      0:       return ack_a;
      1:       return ack_b;
      default: return ack_c;
    endcase
  endfunction

  task automatic check_resp(input int s, input logic [31:0] q, input logic m, input logic p);
    want_t w;
    int    n;
    n = (s == 0) ? qa.size() : (s == 1) ? qb.size() : qc.size();
    if (n == 0) begin
      chk($sformatf("spurious_ack%0d", s), 32'(n), 32'd1);
    end else begin
      if (s == 0) w = qa.pop_front();
      else if (s == 1) w = qb.pop_front();
      else w = qc.pop_front();
      if (w.chk_q) chk($sformatf("q%0d", s), q, w.q);
      chk($sformatf("misaligned%0d", s), {31'd0, m}, {31'd0, w.mis});
      chk($sformatf("page_fault%0d", s), {31'd0, p}, {31'd0, w.pf});
    end
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (ack_a) check_resp(0, q_a, mis_a, pf_a);
      if (ack_b) check_resp(1, q_b, mis_b, pf_b);
      if (ack_c) check_resp(2, q_c, mis_c, pf_c);
    end
  end

  // Predicts the response, updates the model, drives the request and waits for ack.
  task automatic do_req(input int s, input logic w, input logic [31:0] a, input logic [31:0] dd,
                        input biu_size_t sz, input bit hold, input int lat);
    want_t       e;
    logic [31:0] base, off, cur;
    logic [1:0]  lo;
    int          key, n;
    base    = (s == 1) ? 32'h0000_1000 : 32'h0000_0000;
    off     = a - base;
    lo      = a[1:0];
    e.mis   = (sz == DWORD) || (sz == WORD && lo != 2'd0) || (sz == HWORD && lo[0]);
    e.pf    = !e.mis && (off >= 32'd4096);
    e.chk_q = !w || e.mis || e.pf;
    e.q     = 32'h0;
    if (!e.mis && !e.pf) begin
      key = s * 4096 + int'(off[11:2]);
      cur = mdl.exists(key) ? mdl[key] : 32'h0;
      if (w) begin
        for (int b = 0; b < 4; b++) begin
          if (sz == WORD) cur[8*b +: 8] = dd[8*b +: 8];
          else if (sz == BYTE && b == int'(lo)) cur[8*b +: 8] = dd[7:0];
          else if (sz == HWORD && (b == int'(lo) || b == int'(lo) + 1))
            cur[8*b +: 8] = dd[8*(b - int'(lo)) +: 8];
        end
        mdl[key] = cur;
      end else begin
        e.q = cur;
      end
    end
    if (s == 0) qa.push_back(e);
    else if (s == 1) qb.push_back(e);
    else qc.push_back(e);
    sel = s; we = w; adr = a; d = dd; size = sz; req = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ack_of(s) && n < 40);
    chk($sformatf("latency%0d", s), 32'(n), 32'(lat));
    if (!hold) begin
      req = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("ack_width%0d", s), {31'd0, ack_of(s)}, 32'd0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ack"}, {29'd0, ack_a, ack_b, ack_c}, 32'd0);
    chk({tag, "_q_a"}, q_a, 32'd0);
    chk({tag, "_q_b"}, q_b, 32'd0);
    chk({tag, "_q_c"}, q_c, 32'd0);
    chk({tag, "_mis"}, {29'd0, mis_a, mis_b, mis_c}, 32'd0);
    chk({tag, "_pf"}, {29'd0, pf_a, pf_b, pf_c}, 32'd0);
  endtask

  initial begin
    rstn = 1'b0; req = 1'b0; we = 1'b0; adr = 32'h0; d = 32'h0; size = WORD; sel = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rstn = 1'b1;
    @(posedge clk); #1;

    // LATENCY=1: back-to-back write then read, byte merge, alignment errors
    do_req(0, 1'b1, 32'h10, 32'hDEAD_BEEF, WORD, 1'b1, 1);
    do_req(0, 1'b0, 32'h10, 32'h0, WORD, 1'b0, 1);
    do_req(0, 1'b1, 32'h10, 32'h1122_3344, WORD, 1'b0, 1);
    do_req(0, 1'b1, 32'h13, 32'h0000_00A5, BYTE, 1'b0, 1);
    do_req(0, 1'b0, 32'h10, 32'h0, WORD, 1'b0, 1);
    do_req(0, 1'b1, 32'h20, 32'hCAFE_F00D, WORD, 1'b0, 1);
    do_req(0, 1'b1, 32'h21, 32'h0000_FFFF, HWORD, 1'b0, 1);
    do_req(0, 1'b0, 32'h20, 32'h0, DWORD, 1'b0, 1);
    do_req(0, 1'b0, 32'h20, 32'h0, WORD, 1'b0, 1);
    do_req(0, 1'b1, 32'h22, 32'h0000_BEEF, HWORD, 1'b0, 1);
    do_req(0, 1'b0, 32'h20, 32'h0, WORD, 1'b0, 1);

    // Random mixed traffic over a pre-initialised window
    for (int i = 0; i < 8; i++) do_req(0, 1'b1, 32'h100 + 32'(4 * i), $urandom, WORD, 1'b1, 1);
    for (int i = 0; i < 30; i++) begin
      do_req(0, 1'(($urandom_range(0, 1))), 32'h100 + 32'($urandom_range(0, 31)), $urandom,
             biu_size_t'($urandom_range(0, 3)), (i < 29) ? 1'($urandom_range(0, 1)) : 1'b0, 1);
    end

    // BASE=0x1000: range edges, and a faulting write must not alias into the array
    do_req(1, 1'b0, 32'h0000_0FFC, 32'h0, WORD, 1'b0, 1);
    do_req(1, 1'b0, 32'h0000_2000, 32'h0, WORD, 1'b0, 1);
    do_req(1, 1'b1, 32'h0000_1FFC, 32'h0BAD_CAFE, WORD, 1'b0, 1);
    do_req(1, 1'b0, 32'h0000_1FFC, 32'h0, WORD, 1'b0, 1);
    do_req(1, 1'b1, 32'h0000_1000, 32'h600D_F00D, WORD, 1'b0, 1);
    do_req(1, 1'b1, 32'h0000_2000, 32'hFFFF_FFFF, WORD, 1'b0, 1);
    do_req(1, 1'b0, 32'h0000_1000, 32'h0, WORD, 1'b0, 1);
    do_req(1, 1'b0, 32'hFFFF_FFFC, 32'h0, WORD, 1'b0, 1);

    // LATENCY=4: single-cycle ack, held request gives the next ack four cycles later
    do_req(2, 1'b1, 32'h40, 32'h1234_5678, WORD, 1'b0, 4);
    do_req(2, 1'b0, 32'h40, 32'h0, WORD, 1'b1, 4);
    do_req(2, 1'b0, 32'h40, 32'h0, WORD, 1'b0, 4);

    // Reset in cycle 2 of a LATENCY=4 write: write dropped, outputs cleared
    sel = 2; we = 1'b1; adr = 32'h40; d = 32'h0000_0055; size = WORD; req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstn = 1'b0;
    req  = 1'b0;
    #1;
    check_reset_outputs("abort");
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("abort_hold");
    rstn = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    do_req(2, 1'b0, 32'h40, 32'h0, WORD, 1'b0, 4);

    repeat (2) @(posedge clk);
    chk("leftover", 32'(qa.size() + qb.size() + qc.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/riscv_dmem_tcm.md
# riscv_dmem_tcm

Single-ported, tightly-coupled data memory that responds to the EX-stage data-memory request interface (`dmem_*`). It sits between the execution stage's load-store path and on-chip SRAM. It accepts one request at a time and checks size/alignment and address range. It performs byte-lane-masked writes or full-word reads after a programmable latency, then returns a one-cycle acknowledge with read data or an error flag.

## Interface
- XLEN, 32: data/address width; only 32 supported (64 reserved).
- BASE, 'h0000_0000: byte address of the first memory location.
- DEPTH, 1024: number of XLEN-wide words; power of two.
- LATENCY, 1: cycles from request capture to acknowledge; legal range 1..15.

Ports:
- rstn  in  1  reset rstn, asynchronous, active-low
- clk  in  1  clock clk
- dmem_req  in  1  request valid; held with all request fields stable until dmem_ack
- dmem_we  in  1  1 = write, 0 = read
- dmem_adr  in  XLEN  byte address
- dmem_d  in  XLEN  write data, right-justified (byte in [7:0], halfword in [15:0])
- dmem_size  in  biu_size_t  BYTE, HWORD, WORD, DWORD
- dmem_ack  out  1  one-cycle completion strobe
- dmem_q  out  XLEN  full aligned word at adr[XLEN-1:2]; valid only while dmem_ack=1
- dmem_misaligned  out  1  error: misaligned or unsupported size; valid with dmem_ack
- dmem_page_fault  out  1  error: address outside [BASE, BASE+4*DEPTH); valid with dmem_ack

## Operation
- FSM states are IDLE, BUSY, and RESP.
- IDLE: on a rising edge with dmem_req=1, capture adr/we/d/size, load cnt=LATENCY-1, and compute errors.
  - If LATENCY=1, go directly to RESP. Otherwise go to BUSY.
- BUSY: cnt decrements each edge. At the edge where cnt=0, go to RESP.
- The memory access happens on the edge that enters RESP (write commit or read sample).
- RESP: dmem_ack=1 for exactly one cycle.
  - If dmem_req=1 in the RESP cycle, it is a new request: capture it as in IDLE (back-to-back).
  - Otherwise return to IDLE.
- Misaligned is set when any of these holds:
  - HWORD and adr[0]=1;
  - WORD and adr[1:0]≠0;
  - DWORD (always, XLEN=32).
- page_fault is set when (adr−BASE) ≥ 4·DEPTH, using unsigned wrap-around subtraction.
  - page_fault is evaluated only if not misaligned; misaligned has priority and at most one flag is set.
- On error: no memory write, dmem_q=0, and the error flag is asserted together with dmem_ack.
- Byte enables:
  - BYTE: 4'b0001<<adr[1:0];
  - HWORD: 4'b0011<<adr[1:0];
  - WORD: 4'b1111.
- Write data is replicated into lanes: BYTE uses {4{d[7:0]}}, HWORD uses {2{d[15:0]}}. Only enabled lanes are updated.
- Reads always return the whole word. Lane extraction and sign extension belong to the requester.
- Memory index is (adr−BASE)[log2(DEPTH)+1:2]. Memory contents are not reset.

## Timing
- Reset values: dmem_ack=0, dmem_q=0, dmem_misaligned=0, dmem_page_fault=0, state=IDLE, cnt=0.
- Request sampled at edge E0. dmem_ack is high in the cycle after edge E0+(LATENCY−1), i.e. LATENCY cycles after capture.
- Throughput is one access per LATENCY cycles. With LATENCY=1 and dmem_req held high, dmem_ack stays high every cycle.
- All outputs are registered; there is no combinational path from inputs to dmem_ack/dmem_q/flags.
- Read-after-write back-to-back to the same word returns the newly written data.
- A dmem_req deassertion while in BUSY is a protocol violation. The transaction still completes and dmem_ack is still issued.
- Reset asserted in BUSY or RESP aborts immediately and all outputs go to their reset values.
  - A write whose commit edge has not yet occurred is not performed.
  - A write already committed persists.
- cnt width is 4 bits. LATENCY>15 is flagged by an elaboration-time error.

## Test plan
- LATENCY=1, BASE=0: WORD write 0xDEADBEEF to 0x10, then a back-to-back WORD read of 0x10 -> dmem_ack high in both response cycles; read dmem_q=0xDEADBEEF.
- BYTE write d=0x000000A5 at 0x13 over 0x11223344 -> a subsequent read of 0x10 returns 0xA5223344.
- HWORD access at 0x21 -> dmem_ack=1 with dmem_misaligned=1, dmem_page_fault=0, dmem_q=0; memory unchanged. DWORD at 0x20 -> misaligned=1.
- DEPTH=1024, BASE=0x1000: reads of 0x0FFC and 0x2000 -> page_fault=1. A read of 0x1FFC -> no error.
- LATENCY=4: read request at cycle 0 -> dmem_ack only in cycle 4, one cycle wide. dmem_req held into cycle 4 -> next ack in cycle 8.
- LATENCY=4: write of 0x55 to 0x40, with rstn pulsed in cycle 2 -> no ack. A later read of 0x40 returns the old value; all outputs are 0 during reset.
